multicycle_core: RTL

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/mc_pkg.sv | 73 +++++++
 rtl/mc_regfile.sv | 45 ++++
 rtl/multicycle_core.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I/E subset core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_pkg;

    // Controller states; one instruction walks FETCH..WB, HALT is terminal until reset
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    // ALU control encoding
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    // Instruction class picked in DECODE; drives EXEC/MEM/WB behaviour
    typedef enum logic [2:0] {
        CL_ALU_I  = 3'd0,
        CL_ALU_R  = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_BRANCH = 3'd4,
        CL_JAL    = 3'd5
    } iclass_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // True when a register index exists in a file of nregs entries
    function automatic logic reg_ok(input logic [4:0] idx, input int nregs);
        return (int'(idx) < nregs);
    endfunction

    // 32-bit ALU; arithmetic wraps, SLT is signed
    function automatic logic [31:0] alu_calc(input alu_op_e op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_SLT: r = {31'd0, ($signed(a) < $signed(b))};
            default: r = a + b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// Register file: NREGS entries, two read ports, one write port, debug read port.
// Latency: reads combinational, write visible the cycle after we_i.
// Backpressure: none; x0 and out-of-range indices read 0 and ignore writes.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    output logic [XLEN-1:0] rdata1_o,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata2_o,
    input  logic [4:0]      dbg_raddr_i,
    output logic [XLEN-1:0] dbg_rdata_o
);

    localparam int AW = $clog2(NREGS);

    // Entry 0 exists but is never written, so x0 always reads back 0 via the guard
    logic [XLEN-1:0] regs_q [NREGS];

    function automatic logic live(input logic [4:0] idx);
        return (idx != 5'd0) && reg_ok(idx, NREGS);
    endfunction

    // Read ports gate index 0 and indices beyond the file to zero
    always_comb begin
        rdata1_o    = live(raddr1_i)    ? regs_q[raddr1_i[AW-1:0]]    : '0;
        rdata2_o    = live(raddr2_i)    ? regs_q[raddr2_i[AW-1:0]]    : '0;
        dbg_rdata_o = live(dbg_raddr_i) ? regs_q[dbg_raddr_i[AW-1:0]] : '0;
    end

    // Write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_i && live(waddr_i)) begin
            regs_q[waddr_i[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I/E subset core (ADDI ADD SUB AND OR SLT LW SW BEQ JAL), one shared memory port.
// Latency: BEQ 3, ALU/SW/JAL 4, LW 5 cycles with zero-wait memory.
// Backpressure: FETCH/MEM hold all outputs until mem_ready; each low cycle adds one cycle.
module multicycle_core
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     retired,
    output logic            halted,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] res_q, res_d;      // ALU result, then memory address, then load data
    logic [31:0]     retired_q, retired_d;
    iclass_e         cls_q, cls_d;
    alu_op_e         aop_q, aop_d;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

    logic            dec_valid, use_rd, use_rs1, use_rs2;
    iclass_e         dec_cls;
    alu_op_e         dec_aop;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] alu_opb, alu_out, pc_plus4, pc_target;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata, rf_rdata1, rf_rdata2;

    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Instruction decode: class, ALU op, immediate and which register fields are real
    always_comb begin
        dec_valid = 1'b0;
        dec_cls   = CL_ALU_I;
        dec_aop   = ALU_ADD;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opc)
            OPC_OP_IMM: begin
                dec_valid = (f3 == F3_ADD);
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
            end
            OPC_OP: begin
                dec_cls   = CL_ALU_R;
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                dec_valid = 1'b1;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: dec_aop = ALU_ADD;
                    {F7_SUB,  F3_ADD}: dec_aop = ALU_SUB;
                    {F7_BASE, F3_AND}: dec_aop = ALU_AND;
                    {F7_BASE, F3_OR}:  dec_aop = ALU_OR;
                    {F7_BASE, F3_SLT}: dec_aop = ALU_SLT;
                    default:           dec_valid = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec_cls   = CL_LOAD;
                dec_valid = (f3 == F3_LW);
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
            end
            OPC_STORE: begin
                dec_cls   = CL_STORE;
                dec_valid = (f3 == F3_SW);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_cls   = CL_BRANCH;
                dec_valid = (f3 == F3_BEQ);
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
            end
            OPC_JAL: begin
                dec_cls   = CL_JAL;
                dec_valid = 1'b1;
                use_rd    = 1'b1;
            end
            default: dec_valid = 1'b0;
        endcase
        // RV32E builds trap on x16..x31 in any field the instruction actually uses
        if ((use_rd && !reg_ok(rd, NREGS)) || (use_rs1 && !reg_ok(rs1, NREGS)) ||
            (use_rs2 && !reg_ok(rs2, NREGS))) begin
            dec_valid = 1'b0;
        end
        case (dec_cls)
            CL_STORE:  dec_imm = imm_s;
            CL_BRANCH: dec_imm = imm_b;
            CL_JAL:    dec_imm = imm_j;
            CL_ALU_R:  dec_imm = '0;
            default:   dec_imm = imm_i;
        endcase
    end

    assign alu_opb   = (cls_q == CL_ALU_R) ? rs2_q : imm_q;
    assign alu_out   = alu_calc(aop_q, rs1_q, alu_opb);
    assign pc_plus4  = pc_q + XLEN'(4);
    assign pc_target = pc_q + imm_q;

    // Next-state, datapath updates and memory-port outputs per state
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_d     = imm_q;
        res_d     = res_q;
        retired_d = retired_q;
        cls_d     = cls_q;
        aop_d     = aop_q;
        rf_we     = 1'b0;
        rf_wdata  = res_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        mem_wdata = '0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                rs1_d   = rf_rdata1;
                rs2_d   = rf_rdata2;
                imm_d   = dec_imm;
                cls_d   = dec_cls;
                aop_d   = dec_aop;
                state_d = dec_valid ? EXEC : HALT;
            end
            EXEC: begin
                case (cls_q)
                    CL_ALU_I, CL_ALU_R: begin
                        res_d   = alu_out;
                        state_d = WB;
                    end
                    CL_JAL: state_d = WB;
                    CL_LOAD, CL_STORE: begin
                        // Misaligned accesses trap before any request is issued
                        if (alu_out[1:0] != 2'b00) begin
                            state_d = HALT;
                        end else begin
                            res_d   = alu_out;
                            state_d = MEM;
                        end
                    end
                    CL_BRANCH: begin
                        pc_d      = (rs1_q == rs2_q) ? pc_target : pc_plus4;
                        retired_d = retired_q + 32'd1;
                        state_d   = FETCH;
                    end
                    default: state_d = HALT;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_addr = res_q;
                mem_we   = (cls_q == CL_STORE);
                if (cls_q == CL_STORE) begin
                    mem_wdata = rs2_q;
                end
                if (mem_ready) begin
                    if (cls_q == CL_STORE) begin
                        pc_d      = pc_plus4;
                        retired_d = retired_q + 32'd1;
                        state_d   = FETCH;
                    end else begin
                        res_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we     = 1'b1;
                rf_wdata  = (cls_q == CL_JAL) ? pc_plus4 : res_q;
                pc_d      = (cls_q == CL_JAL) ? pc_target : pc_plus4;
                retired_d = retired_q + 32'd1;
                state_d   = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // State and datapath registers; reset overrides every update in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            res_q     <= '0;
            retired_q <= '0;
            cls_q     <= CL_ALU_I;
            aop_q     <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_q     <= imm_d;
            res_q     <= res_d;
            retired_q <= retired_d;
            cls_q     <= cls_d;
            aop_q     <= aop_d;
        end
    end

    mc_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk         (clk),
        .we_i        (rf_we & ~rst),
        .waddr_i     (rd),
        .wdata_i     (rf_wdata),
        .raddr1_i    (rs1),
        .rdata1_o    (rf_rdata1),
        .raddr2_i    (rs2),
        .rdata2_o    (rf_rdata2),
        .dbg_raddr_i (dbg_raddr),
        .dbg_rdata_o (dbg_rdata)
    );

    assign pc      = pc_q;
    assign retired = retired_q;
    assign halted  = (state_q == HALT);

endmodule
